// File: rtl/oam_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | oam_pkg : OAM geometry, object layout and evaluation FSM encodings          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package oam_pkg;

    localparam int c_NUM_OBJ = 64;
    localparam int c_MAX_SPR = 8;
    localparam int c_SPR_H   = 8;

    localparam int c_BYTE_Y    = 0;
    localparam int c_BYTE_TILE = 1;
    localparam int c_BYTE_ATTR = 2;
    localparam int c_BYTE_X    = 3;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] attr;
        logic [7:0] tile;
        logic [7:0] y;
    } oam_obj_t;

    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_CPU_ACC = 3'd1;
    localparam state_t c_ST_CPU_RSP = 3'd2;
    localparam state_t c_ST_EVAL    = 3'd3;
    localparam state_t c_ST_DRAIN   = 3'd4;
    localparam state_t c_ST_FIN     = 3'd5;

endpackage
`default_nettype wire

// File: rtl/sprite_range_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sprite_range_cmp : vertical in-range test of one object against a scanline  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module sprite_range_cmp
    import oam_pkg::*;
#(
    parameter int SPR_H = c_SPR_H
) (
    input  logic [7:0] i_scanline,
    input  logic [7:0] i_y,
    output logic       o_in_range
);

    localparam logic [8:0] c_HEIGHT = 9'(SPR_H);

    logic [8:0] w_diff;

    // 9-bit difference: the borrow bit rejects objects below the line, no wrap
    assign w_diff     = {1'b0, i_scanline} - {1'b0, i_y};
    assign o_in_range = !w_diff[8] && (w_diff < c_HEIGHT);

endmodule
`default_nettype wire

// File: rtl/sprite_eval_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sprite_eval_ctrl : OAM port owner arbitrating CPU access and sprite eval    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module sprite_eval_ctrl
    import oam_pkg::*;
#(
    parameter int NUM_OBJ = c_NUM_OBJ,
    parameter int MAX_SPR = c_MAX_SPR,
    parameter int SPR_H   = c_SPR_H
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         eval_start,
    input  logic [7:0]                   scanline,
    input  logic                         cpu_req,
    input  logic                         cpu_rw,
    input  logic [5:0]                   cpu_addr,
    input  logic [31:0]                  cpu_wdata,
    output logic                         cpu_ack,
    output logic [31:0]                  cpu_rdata,
    output logic                         oam_en,
    output logic                         oam_rw,
    output logic [5:0]                   oam_addr,
    output logic [31:0]                  oam_wdata,
    input  logic [31:0]                  oam_rdata,
    output logic                         spr_wr_en,
    output logic [$clog2(MAX_SPR)-1:0]   spr_wr_idx,
    output logic [31:0]                  spr_wr_data,
    output logic [$clog2(MAX_SPR+1)-1:0] spr_count,
    output logic                         spr_overflow,
    output logic                         busy,
    output logic                         done
);

    localparam int c_IW = $clog2(MAX_SPR);
    localparam int c_CW = $clog2(MAX_SPR + 1);
    localparam logic [c_CW-1:0] c_MAX_CNT   = c_CW'(MAX_SPR);
    localparam logic [5:0]      c_LAST_ADDR = 6'(NUM_OBJ - 1);

    state_t     r_state;
    logic [7:0] r_line;
    logic       r_pend;
    logic [7:0] r_pend_line;
    logic       r_eval_vld;
    logic       w_in_range;

    sprite_range_cmp #(.SPR_H(SPR_H)) u_range_cmp (
        .i_scanline (r_line),
        .i_y        (oam_rdata[c_BYTE_Y*8 +: 8]),
        .o_in_range (w_in_range)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_line       <= '0;
            r_pend       <= 1'b0;
            r_pend_line  <= '0;
            r_eval_vld   <= 1'b0;
            cpu_ack      <= 1'b0;
            cpu_rdata    <= '0;
            oam_en       <= 1'b0;
            oam_rw       <= 1'b0;
            oam_addr     <= '0;
            oam_wdata    <= '0;
            spr_wr_en    <= 1'b0;
            spr_wr_idx   <= '0;
            spr_wr_data  <= '0;
            spr_count    <= '0;
            spr_overflow <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            cpu_ack    <= 1'b0;
            done       <= 1'b0;
            spr_wr_en  <= 1'b0;
            oam_en     <= 1'b0;
            // Every EVAL cycle issues a read, so its data is valid one cycle later
            r_eval_vld <= (r_state == c_ST_EVAL);

            if (eval_start && (r_state != c_ST_IDLE)) begin
                r_pend      <= 1'b1;
                r_pend_line <= scanline;
            end

            if (r_eval_vld && w_in_range) begin
                if (spr_count < c_MAX_CNT) begin
                    spr_wr_en   <= 1'b1;
                    spr_wr_idx  <= spr_count[c_IW-1:0];
                    spr_wr_data <= oam_rdata;
                    spr_count   <= spr_count + 1'b1;
                end else begin
                    spr_overflow <= 1'b1;
                end
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (r_pend || eval_start) begin
                        r_state      <= c_ST_EVAL;
                        r_line       <= eval_start ? scanline : r_pend_line;
                        r_pend       <= 1'b0;
                        spr_count    <= '0;
                        spr_overflow <= 1'b0;
                        busy         <= 1'b1;
                        oam_en       <= 1'b1;
                        oam_rw       <= 1'b0;
                        oam_addr     <= '0;
                    end else if (cpu_req) begin
                        r_state   <= c_ST_CPU_ACC;
                        oam_en    <= 1'b1;
                        oam_rw    <= cpu_rw;
                        oam_addr  <= cpu_addr;
                        oam_wdata <= cpu_wdata;
                    end
                end
                c_ST_CPU_ACC: r_state <= c_ST_CPU_RSP;
                c_ST_CPU_RSP: begin
                    cpu_ack <= 1'b1;
                    if (!oam_rw) begin
                        cpu_rdata <= oam_rdata;
                    end
                    r_state <= c_ST_IDLE;
                end
                c_ST_EVAL: begin
                    if (oam_addr == c_LAST_ADDR) begin
                        r_state <= c_ST_DRAIN;
                    end else begin
                        oam_en   <= 1'b1;
                        oam_addr <= oam_addr + 1'b1;
                    end
                end
                c_ST_DRAIN: begin
                    done    <= 1'b1;
                    r_state <= c_ST_FIN;
                end
                c_ST_FIN: begin
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_eval_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sprite_eval_ctrl : table-driven and sequence bench with write scoreboard |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_sprite_eval_ctrl;

    localparam int SPR_H   = 8;
    localparam int MAX_SPR = 8;

    logic        clk;
    logic        rst_n;
    logic        eval_start;
    logic [7:0]  scanline;
    logic        cpu_req;
    logic        cpu_rw;
    logic [5:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        oam_en;
    logic        oam_rw;
    logic [5:0]  oam_addr;
    logic [31:0] oam_wdata;
    logic [31:0] oam_rdata;
    logic        spr_wr_en;
    logic [2:0]  spr_wr_idx;
    logic [31:0] spr_wr_data;
    logic [3:0]  spr_count;
    logic        spr_overflow;
    logic        busy;
    logic        done;

    sprite_eval_ctrl #(.NUM_OBJ(64), .MAX_SPR(MAX_SPR), .SPR_H(SPR_H)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .eval_start   (eval_start),
        .scanline     (scanline),
        .cpu_req      (cpu_req),
        .cpu_rw       (cpu_rw),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ack      (cpu_ack),
        .cpu_rdata    (cpu_rdata),
        .oam_en       (oam_en),
        .oam_rw       (oam_rw),
        .oam_addr     (oam_addr),
        .oam_wdata    (oam_wdata),
        .oam_rdata    (oam_rdata),
        .spr_wr_en    (spr_wr_en),
        .spr_wr_idx   (spr_wr_idx),
        .spr_wr_data  (spr_wr_data),
        .spr_count    (spr_count),
        .spr_overflow (spr_overflow),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // OAM model: single port, registered read data, high-Z when not valid
    logic [31:0] mem [64];
    logic [31:0] oam_q;
    logic        oam_vld;
    always @(posedge clk) begin
        oam_vld <= oam_en && !oam_rw;
        if (oam_en) begin
            if (oam_rw) mem[oam_addr] = oam_wdata;
            else        oam_q <= mem[oam_addr];
        end
    end
    assign oam_rdata = oam_vld ? oam_q : 32'bz;

    typedef struct packed {
        logic [2:0]  idx;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        int         pat;
        logic [7:0] line;
        logic [3:0] cnt;
        logic       ovf;
    } vec_t;
    vec_t tbl[8];

    int checks;
    int errors;

    function automatic logic [127:0] all_outs();
        return {cpu_ack, cpu_rdata, oam_en, oam_rw, oam_addr, oam_wdata, spr_wr_en,
                spr_wr_idx, spr_wr_data, spr_count, spr_overflow, busy, done};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_pattern(input int p);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] y;
            y = 8'hF0;
            case (p)
                0: if (i == 3 || i == 7) y = 8'd10;
                1: if (i >= 5 && i <= 14) y = 8'd20;
                2: if (i == 9) y = 8'd100;
                3: if (i == 2) y = 8'd250;
                default: y = 8'hF0;
            endcase
            mem[i] = {8'(i + 1), 8'hA5, 8'(i), y};
        end
    endtask

    // Reference selection: lowest indices first, at most MAX_SPR writes
    task automatic push_expected(input logic [7:0] line);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            int y;
            w = mem[i];
            y = int'(w[7:0]);
            if (int'(line) >= y && int'(line) - y < SPR_H) begin
                if (n < MAX_SPR) exp_q.push_back({3'(n), w});
                n++;
            end
        end
    endtask

    task automatic watch(input int ncyc, input int eval_at, input logic [7:0] eval_line,
                         input int cpu_at, input logic [5:0] c_addr, input int rst_at,
                         output int done_k, output int ndone, output int ack_k,
                         output logic [31:0] ack_data, output logic busy_after);
        done_k = 0; ndone = 0; ack_k = 0; ack_data = '0; busy_after = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            if (spr_wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got idx %0d data %0h required none", spr_wr_idx, spr_wr_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_idx", 128'(spr_wr_idx), 128'(e.idx));
                    check("wr_data", 128'(spr_wr_data), 128'(e.data));
                end
            end
            if (done) begin
                ndone++;
                if (done_k == 0) done_k = k;
            end
            if (done_k > 0 && k == done_k + 1) busy_after = busy;
            if (cpu_ack && ack_k == 0) begin
                ack_k    = k;
                ack_data = cpu_rdata;
                cpu_req  = 1'b0;
            end
            if (rst_at > 0 && k == rst_at + 1) check("abort_outputs_zero", all_outs(), 128'd0);
            if (k == eval_at) begin
                eval_start = 1'b1;
                scanline   = eval_line;
                push_expected(eval_line);
            end else begin
                eval_start = 1'b0;
                scanline   = 8'hEE;
            end
            if (k == cpu_at) begin
                cpu_req  = 1'b1;
                cpu_rw   = 1'b0;
                cpu_addr = c_addr;
            end
            if (rst_at > 0 && k == rst_at) rst_n = 1'b0;
            if (rst_at > 0 && k == rst_at + 3) rst_n = 1'b1;
        end
    endtask

    task automatic start_eval(input logic [7:0] line);
        eval_start = 1'b1;
        scanline   = line;
        push_expected(line);
    endtask

    initial begin
        int dk, nd, ak;
        logic [31:0] ad;
        logic ba;
        checks = 0;
        errors = 0;
        rst_n = 1'b0; eval_start = 1'b0; scanline = '0;
        cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        load_pattern(0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 128'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("idle_quiet", 128'({oam_en, busy, done, cpu_ack}), 128'd0);
        end

        tbl[0] = '{0, 8'd12,  4'd2, 1'b0};
        tbl[1] = '{1, 8'd20,  4'd8, 1'b1};
        tbl[2] = '{2, 8'd107, 4'd1, 1'b0};
        tbl[3] = '{2, 8'd108, 4'd0, 1'b0};
        tbl[4] = '{2, 8'd99,  4'd0, 1'b0};
        tbl[5] = '{2, 8'd100, 4'd1, 1'b0};
        tbl[6] = '{3, 8'd5,   4'd0, 1'b0};
        tbl[7] = '{1, 8'd27,  4'd8, 1'b1};
        for (int t = 0; t < 8; t++) begin
            load_pattern(tbl[t].pat);
            start_eval(tbl[t].line);
            watch(72, 0, 8'd0, 0, 6'd0, 0, dk, nd, ak, ad, ba);
            check("done_cycle", 128'(dk), 128'd66);
            check("done_pulses", 128'(nd), 128'd1);
            check("spr_count", 128'(spr_count), 128'(tbl[t].cnt));
            check("spr_overflow", 128'(spr_overflow), 128'(tbl[t].ovf));
            check("writes_missing", 128'(exp_q.size()), 128'd0);
            check("busy_after_done", 128'(ba), 128'd0);
        end

        // CPU write then read back; ack two edges after the accepting edge
        load_pattern(0);
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 6'd5; cpu_wdata = 32'hDEADBEEF;
        watch(8, 0, 8'd0, 0, 6'd0, 0, dk, nd, ak, ad, ba);
        check("cpu_wr_latency", 128'(ak), 128'd3);
        check("oam_written", 128'(mem[5]), 128'hDEADBEEF);
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 6'd5;
        watch(8, 0, 8'd0, 0, 6'd0, 0, dk, nd, ak, ad, ba);
        check("cpu_rd_latency", 128'(ak), 128'd3);
        check("cpu_rd_data", 128'(ad), 128'hDEADBEEF);

        // CPU request at eval cycle 10 waits for the evaluation to finish
        load_pattern(0);
        start_eval(8'd12);
        watch(75, 0, 8'd0, 10, 6'd3, 0, dk, nd, ak, ad, ba);
        check("stall_done_cycle", 128'(dk), 128'd66);
        check("stall_ack_cycle", 128'(ak), 128'd70);
        check("stall_rd_data", 128'(ad), 128'(mem[3]));
        check("stall_writes_missing", 128'(exp_q.size()), 128'd0);

        // eval_start during CPU_ACC: CPU acks first, eval uses captured line
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 6'd7;
        watch(75, 1, 8'd12, 0, 6'd0, 0, dk, nd, ak, ad, ba);
        check("pend_ack_cycle", 128'(ak), 128'd3);
        check("pend_rd_data", 128'(ad), 128'(mem[7]));
        check("pend_done_cycle", 128'(dk), 128'd69);
        check("pend_count", 128'(spr_count), 128'd2);
        check("pend_writes_missing", 128'(exp_q.size()), 128'd0);

        // eval_start and cpu_req together in IDLE: eval wins
        start_eval(8'd12);
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 6'd9;
        watch(75, 0, 8'd0, 0, 6'd0, 0, dk, nd, ak, ad, ba);
        check("prio_done_cycle", 128'(dk), 128'd66);
        check("prio_ack_cycle", 128'(ak), 128'd70);
        check("prio_rd_data", 128'(ad), 128'(mem[9]));

        // Reset at eval cycle 30 aborts without done
        load_pattern(1);
        start_eval(8'd20);
        watch(75, 0, 8'd0, 0, 6'd0, 30, dk, nd, ak, ad, ba);
        check("abort_no_done", 128'(nd), 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        exp_q.delete();

        load_pattern(0);
        start_eval(8'd12);
        watch(72, 0, 8'd0, 0, 6'd0, 0, dk, nd, ak, ad, ba);
        check("recover_done_cycle", 128'(dk), 128'd66);
        check("recover_count", 128'(spr_count), 128'd2);
        check("recover_overflow", 128'(spr_overflow), 128'd0);
        check("recover_writes_missing", 128'(exp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
